tdm_delay_framer: RTL and testbench

Parametrised successor of the TDM/STM stream converter, running entirely in the `clk50` domain. It oversamples the `c4`/`f0` TDM timing and the STM serial clock and data, and delays `LANES` parallel STM bit streams by `DELAY_BITS` STM clocks through a circular buffer. It tracks frame position against `f0`, generates programmable slot strobes, and reports frame lock and sync errors. It sits between the STM32 serial port and the TDM backplane interface.

---
 rtl/tdm_conv_pkg.sv | 30 +++
 rtl/tdm_edge_sync.sv | 51 +++++
 rtl/tdm_delay_framer.sv | 188 ++++++++++++++++++
 tb/tb_tdm_delay_framer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_conv_pkg.sv
// Shared types and constants for the TDM/STM delay framer.
// Holds the lock-state encoding, the default parameters and a clog2 helper.
package tdm_conv_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    localparam int DEF_DELAY_BITS  = 384;
    localparam int DEF_LANES       = 1;
    localparam int DEF_FRAME_BITS  = 1024;
    localparam int DEF_SLOT_PERIOD = 24;
    localparam int DEF_SLOT_COUNT  = 3;
    localparam int DEF_SYNC_STAGES = 2;

    // Never returns less than 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tdm_edge_sync.sv
// Oversampling synchroniser for a sampled clock plus its data bundle.
// Decodes rise/fall from the last stage and masks edges right after reset.
module tdm_edge_sync
    import tdm_conv_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic             clk_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             rise,
    output logic             fall
);

    localparam int              MW        = clog2(STAGES + 2);
    localparam logic [MW-1:0]   MASK_DONE = MW'(STAGES + 1);

    // Bit 0 of every stage carries the clock, the upper bits its data.
    logic [STAGES-1:0][WIDTH:0] sync_q, sync_d;
    logic                       hist_q, hist_d;
    logic [MW-1:0]              mask_q, mask_d;
    logic                       armed;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], {data_in, clk_in}};
        hist_d = sync_q[STAGES-1][0];
        mask_d = (mask_q == MASK_DONE) ? mask_q : mask_q + 1'b1;
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            mask_q <= '0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            mask_q <= mask_d;
        end
    end

    // Until the chain has refilled, a level already present at release looks like an edge.
    assign armed    = (mask_q == MASK_DONE);
    assign rise     = armed &  sync_q[STAGES-1][0] & ~hist_q;
    assign fall     = armed & ~sync_q[STAGES-1][0] &  hist_q;
    assign data_out = sync_q[STAGES-1][WIDTH:1];

endmodule

// File: rtl/tdm_delay_framer.sv
// Delays STM serial lanes by DELAY_BITS STM clocks and tracks TDM frame position,
// slot strobes and frame lock, all oversampled in the clk50 domain.
module tdm_delay_framer
    import tdm_conv_pkg::*;
#(
    parameter int DELAY_BITS  = DEF_DELAY_BITS,
    parameter int LANES       = DEF_LANES,
    parameter int FRAME_BITS  = DEF_FRAME_BITS,
    parameter int SLOT_PERIOD = DEF_SLOT_PERIOD,
    parameter int SLOT_COUNT  = DEF_SLOT_COUNT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                         clk50,
    input  logic                         reset,
    input  logic                         c4,
    input  logic                         f0,
    input  logic                         clk_from_stm,
    input  logic [LANES-1:0]             data_from_stm,
    input  logic                         bypass,
    output logic [LANES-1:0]             data_to_stm,
    output logic                         slot_strobe,
    output logic [clog2(FRAME_BITS)-1:0] frame_pos,
    output logic                         frame_lock,
    output logic                         sync_err
);

    localparam int AW  = clog2(DELAY_BITS);
    localparam int FW  = clog2(DELAY_BITS + 1);
    localparam int PW  = clog2(FRAME_BITS);
    localparam int PHW = clog2(SLOT_PERIOD);
    localparam int IW  = clog2(SLOT_COUNT + 1);

    localparam logic [AW-1:0]  PTR_LAST   = AW'(DELAY_BITS - 1);
    localparam logic [FW-1:0]  FILL_FULL  = FW'(DELAY_BITS);
    localparam logic [PW-1:0]  POS_LAST   = PW'(FRAME_BITS - 1);
    localparam logic [PHW-1:0] PHASE_LAST = PHW'(SLOT_PERIOD - 1);
    localparam logic [IW-1:0]  IDX_END    = IW'(SLOT_COUNT);

    logic             c4_rise, unused_c4_fall, stm_rise, stm_fall;
    logic [0:0]       f0_s;
    logic [LANES-1:0] stm_data;

    tdm_edge_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_c4_sync (
        .clk50    (clk50),
        .reset    (reset),
        .clk_in   (c4),
        .data_in  (f0),
        .data_out (f0_s),
        .rise     (c4_rise),
        .fall     (unused_c4_fall)
    );

    tdm_edge_sync #(.WIDTH(LANES), .STAGES(SYNC_STAGES)) u_stm_sync (
        .clk50    (clk50),
        .reset    (reset),
        .clk_in   (clk_from_stm),
        .data_in  (data_from_stm),
        .data_out (stm_data),
        .rise     (stm_rise),
        .fall     (stm_fall)
    );

    // ---------------- delay line ----------------
    logic [LANES-1:0] delay_buf [DELAY_BITS];
    logic [LANES-1:0] rd_q;
    logic [LANES-1:0] last_q, last_d, dout_q, dout_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]    fill_q, fill_d;

    // Read is prefetched every cycle; rises are always several cycles after the last write.
    always_ff @(posedge clk50) begin
        if (stm_fall) begin
            delay_buf[wr_ptr_q] <= stm_data;
        end
        rd_q <= delay_buf[wr_ptr_q];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        last_d   = last_q;
        dout_d   = dout_q;
        if (stm_fall) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            fill_d   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
            last_d   = stm_data;
        end
        if (stm_rise) begin
            if (bypass) begin
                dout_d = last_q;
            end else if (fill_q == FILL_FULL) begin
                dout_d = rd_q;
            end else begin
                dout_d = '0;
            end
        end
    end

    // ---------------- frame tracking ----------------
    lock_state_t      state_q, state_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [PHW-1:0]   phase_q, phase_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             strobe_q, strobe_d, f0_prev_q, f0_prev_d, err_q, err_d;

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        strobe_d  = strobe_q;
        f0_prev_d = f0_prev_q;
        err_d     = 1'b0;
        if (c4_rise) begin
            f0_prev_d = f0_s[0];
            if (!f0_s[0]) begin
                pos_d    = '0;
                phase_d  = '0;
                idx_d    = '0;
                strobe_d = 1'b0;
                if (f0_prev_q) begin
                    if (state_q == SEARCH) begin
                        state_d = CHECK;
                    end else if (pos_q == POS_LAST) begin
                        state_d = LOCKED;
                    end else begin
                        state_d = CHECK;
                        err_d   = 1'b1;
                    end
                end
            end else begin
                strobe_d = (phase_q == '0) && (idx_q < IDX_END);
                if (pos_q == POS_LAST) begin
                    pos_d   = '0;
                    phase_d = '0;
                    idx_d   = '0;
                    if (state_q != SEARCH) begin
                        state_d = SEARCH;
                        err_d   = 1'b1;
                    end
                end else begin
                    pos_d = pos_q + 1'b1;
                    if (phase_q == PHASE_LAST) begin
                        phase_d = '0;
                        idx_d   = (idx_q == IDX_END) ? idx_q : idx_q + 1'b1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            last_q    <= '0;
            dout_q    <= '0;
            state_q   <= SEARCH;
            pos_q     <= '0;
            phase_q   <= '0;
            idx_q     <= '0;
            strobe_q  <= 1'b0;
            f0_prev_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            last_q    <= last_d;
            dout_q    <= dout_d;
            state_q   <= state_d;
            pos_q     <= pos_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            strobe_q  <= strobe_d;
            f0_prev_q <= f0_prev_d;
            err_q     <= err_d;
        end
    end

    assign data_to_stm = dout_q;
    assign slot_strobe = strobe_q;
    assign frame_pos   = pos_q;
    assign frame_lock  = (state_q == LOCKED);
    assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_delay_framer.sv
// Randomized bench for tdm_delay_framer against a queue/arithmetic reference model.
module tb_tdm_delay_framer;

    localparam int D   = 384;
    localparam int FB  = 1024;
    localparam int SP  = 24;
    localparam int SC  = 3;
    localparam int HS  = 4;   // STM half period in clk50 cycles
    localparam int HC  = 3;   // c4 half period in clk50 cycles

    logic       clk50 = 1'b0;
    logic       reset = 1'b0;
    logic       c4 = 1'b0;
    logic       f0 = 1'b1;
    logic       clk_from_stm = 1'b0;
    logic [0:0] data_from_stm = '0;
    logic       bypass = 1'b0;
    logic [0:0] data_to_stm;
    logic       slot_strobe;
    logic [9:0] frame_pos;
    logic       frame_lock;
    logic       sync_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit wr_hist[$];
    bit m_last;
    bit exp_dout;
    int m_pos;
    int m_state;   // 0 search, 1 check, 2 locked
    bit m_prev;
    bit m_strobe;
    bit m_err;

    tdm_delay_framer dut (
        .clk50         (clk50),
        .reset         (reset),
        .c4            (c4),
        .f0            (f0),
        .clk_from_stm  (clk_from_stm),
        .data_from_stm (data_from_stm),
        .bypass        (bypass),
        .data_to_stm   (data_to_stm),
        .slot_strobe   (slot_strobe),
        .frame_pos     (frame_pos),
        .frame_lock    (frame_lock),
        .sync_err      (sync_err)
    );

    always #5 clk50 = ~clk50;

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk50);
        #1;
    endtask

    task automatic model_reset();
        wr_hist.delete();
        m_last   = 1'b0;
        m_pos    = 0;
        m_state  = 0;
        m_prev   = 1'b1;
        m_strobe = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic stm_rise(input bit d);
        int n;
        n = wr_hist.size();
        if (bypass)      exp_dout = m_last;
        else if (n >= D) exp_dout = wr_hist[n - D];
        else             exp_dout = 1'b0;
        clk_from_stm  = 1'b1;
        data_from_stm = d;
        wait_cycles(HS);
    endtask

    task automatic stm_fall();
        clk_from_stm = 1'b0;
        wr_hist.push_back(data_from_stm[0]);
        m_last = data_from_stm[0];
        wait_cycles(HS);
    endtask

    task automatic c4_edge(input bit f0v);
        c4 = 1'b0;
        f0 = f0v;
        wait_cycles(HC);
        c4 = 1'b1;
        m_err = 1'b0;
        if (!f0v) begin
            m_strobe = 1'b0;
            if (m_prev) begin
                if (m_state == 0)         m_state = 1;
                else if (m_pos == FB - 1) m_state = 2;
                else begin
                    m_state = 1;
                    m_err   = 1'b1;
                end
            end
            m_pos = 0;
        end else begin
            m_strobe = (m_pos % SP == 0) && (m_pos / SP < SC);
            if (m_pos == FB - 1 && m_state != 0) begin
                m_state = 0;
                m_err   = 1'b1;
            end
            m_pos = (m_pos + 1) % FB;
        end
        m_prev = f0v;
        wait_cycles(HC);
    endtask

    task automatic run_stm(input int n, input string name);
        bit d;
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            d = 1'($urandom);
            stm_rise(d);
            checks++;
            if (data_to_stm[0] !== exp_dout) begin
                errors++;
                bad++;
                $display("FAIL %s rise %0d: data_to_stm=%0b required %0b (writes=%0d)",
                         name, i, data_to_stm[0], exp_dout, wr_hist.size());
            end
            stm_fall();
        end
        $display("stm %s: %0d clocks, %0d bad, writes=%0d", name, n, bad, wr_hist.size());
    endtask

    // One frame: a random-length run of f0 low followed by 'highs' high samples.
    task automatic run_frame(input int highs, input string name, output int strobes, output int errs);
        int lows;
        logic [12:0] got, want;
        lows    = $urandom_range(1, 3);
        strobes = 0;
        errs    = 0;
        for (int i = 0; i < lows + highs; i++) begin
            c4_edge(i >= lows);
            got  = {frame_pos, slot_strobe, frame_lock, sync_err};
            want = {10'(m_pos), m_strobe, m_state == 2, m_err};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s edge %0d: pos=%0d strobe=%0b lock=%0b err=%0b required pos=%0d strobe=%0b lock=%0b err=%0b",
                         name, i, got[12:3], got[2], got[1], got[0], want[12:3], want[2], want[1], want[0]);
            end
            strobes += int'(slot_strobe);
            errs    += int'(sync_err);
        end
        $display("frame %s: lows=%0d highs=%0d strobes=%0d sync_err=%0d lock=%0b pos=%0d",
                 name, lows, highs, strobes, errs, frame_lock, frame_pos);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        model_reset();
        wait_cycles(3);
        checks++;
        if ({data_to_stm, slot_strobe, frame_pos, frame_lock, sync_err} !== 14'd0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h required 0",
                     {data_to_stm, slot_strobe, frame_pos, frame_lock, sync_err});
        end
        reset = 1'b0;
        wait_cycles(6);
        checks++;
        if ({data_to_stm, slot_strobe, frame_pos, frame_lock, sync_err} !== 14'd0) begin
            errors++;
            $display("FAIL reset_release: outputs=%h required 0",
                     {data_to_stm, slot_strobe, frame_pos, frame_lock, sync_err});
        end
    endtask

    task automatic test_delay();
        run_stm(400, "delay");
    endtask

    task automatic test_bypass();
        bypass = 1'b1;
        run_stm(6, "bypass");
        bypass = 1'b0;
        run_stm(6, "resume");
    endtask

    task automatic test_frame_lock();
        int s, e;
        run_frame(FB - 1, "acquire", s, e);
        checks++;
        if (frame_lock !== 1'b0) begin
            errors++;
            $display("FAIL acquire_lock: frame_lock=%0b required 0", frame_lock);
        end
        run_frame(FB - 1, "lock", s, e);
        checks++;
        if (frame_lock !== 1'b1) begin
            errors++;
            $display("FAIL lock_second_start: frame_lock=%0b required 1", frame_lock);
        end
        checks++;
        if (s !== SC) begin
            errors++;
            $display("FAIL strobe_count: strobes=%0d required %0d", s, SC);
        end
        checks++;
        if (e !== 0) begin
            errors++;
            $display("FAIL lock_no_err: sync_err pulses=%0d required 0", e);
        end
    endtask

    task automatic test_short_frame();
        int s, e;
        run_frame(999, "short", s, e);
        run_frame(FB - 1, "recheck", s, e);
        checks++;
        if (e !== 1 || frame_lock !== 1'b0) begin
            errors++;
            $display("FAIL short_err: sync_err pulses=%0d lock=%0b required 1 and 0", e, frame_lock);
        end
        run_frame(FB - 1, "relock", s, e);
        checks++;
        if (frame_lock !== 1'b1) begin
            errors++;
            $display("FAIL relock_from_check: frame_lock=%0b required 1", frame_lock);
        end
    endtask

    task automatic test_missing_frame();
        int s, e;
        run_frame(2 * FB - 1, "missing", s, e);
        checks++;
        if (e !== 1 || frame_lock !== 1'b0) begin
            errors++;
            $display("FAIL missing_err: sync_err pulses=%0d lock=%0b required 1 and 0", e, frame_lock);
        end
        run_frame(FB - 1, "search_restart", s, e);
        checks++;
        if (e !== 0 || frame_lock !== 1'b0) begin
            errors++;
            $display("FAIL search_restart: sync_err pulses=%0d lock=%0b required 0 and 0", e, frame_lock);
        end
        run_frame(FB - 1, "relock2", s, e);
        checks++;
        if (frame_lock !== 1'b1) begin
            errors++;
            $display("FAIL relock2: frame_lock=%0b required 1", frame_lock);
        end
    endtask

    task automatic test_reset_midstream();
        run_stm(200, "pre_reset");
        stm_rise(1'($urandom));
        c4 = 1'b1;
        f0 = 1'b1;
        wait_cycles(2);
        reset = 1'b1;
        model_reset();
        wait_cycles(2);
        checks++;
        if ({data_to_stm, slot_strobe, frame_pos, frame_lock, sync_err} !== 14'd0) begin
            errors++;
            $display("FAIL midstream_reset: outputs=%h required 0",
                     {data_to_stm, slot_strobe, frame_pos, frame_lock, sync_err});
        end
        reset = 1'b0;
        wait_cycles(10);
        checks++;
        if ({data_to_stm, slot_strobe, frame_pos, frame_lock, sync_err} !== 14'd0) begin
            errors++;
            $display("FAIL release_no_edge: outputs=%h required 0",
                     {data_to_stm, slot_strobe, frame_pos, frame_lock, sync_err});
        end
        stm_fall();
        run_stm(390, "refill");
    endtask

    initial begin
        test_reset();
        test_delay();
        test_bypass();
        test_frame_lock();
        test_short_frame();
        test_missing_frame();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
